// File: rtl/joystick_conditioner.sv
// joystick_conditioner: per-channel sync, inversion, debounce, press/release pulses and typematic repeat
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   i_btn[N_CH]       - raw asynchronous pin levels
//   i_repeat_en[N_CH] - per-channel auto-repeat enable (synchronous)
//   o_level[N_CH]     - debounced pressed level (1 = pressed)
//   o_press[N_CH]     - one-cycle pulse on accepted press and on each repeat
//   o_release[N_CH]   - one-cycle pulse on accepted release
//   o_any             - OR of o_level
module joystick_conditioner #(
  parameter int N_CH = 5,
  parameter int ACTIVE_LOW = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  input  logic [N_CH-1:0] i_repeat_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic            o_any
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [N_CH-1:0] sync1, sync2, s;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= {N_CH{ACTIVE_LOW != 0}};
      sync2 <= {N_CH{ACTIVE_LOW != 0}};
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
    end
  assign s = ACTIVE_LOW != 0 ? ~sync2 : sync2;
  assign o_any = |o_level;
  for (genvar g = 0; g < N_CH; g++) begin : ch
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rc;
    state_t st;
    logic level, press, release_p, diff, hit, rise, fall;
    assign diff = s[g] ^ level;
    assign hit = diff && db_cnt == DB_LAST;
    assign rise = hit && !level;
    assign fall = hit && level;
    assign o_level[g] = level;
    assign o_press[g] = press;
    assign o_release[g] = release_p;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        db_cnt <= '0;
        level <= 1'b0;
      end else begin
        db_cnt <= (!diff || hit) ? '0 : db_cnt + DW'(1);
        level <= level ^ hit;
      end
    // A release overrides any repeat pulse falling due on the same edge.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st <= IDLE;
        rc <= '0;
        press <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press <= rise;
        release_p <= fall;
        if (fall) begin
          st <= IDLE;
          rc <= '0;
        end else if (rise) begin
          st <= DELAY;
          rc <= '0;
        end else
          case (st)
            DELAY:
              if (!i_repeat_en[g]) rc <= '0;
              else if (rc == RD_LAST) begin
                press <= 1'b1;
                st <= REPEAT;
                rc <= '0;
              end else rc <= rc + RW'(1);
            REPEAT:
              if (!i_repeat_en[g]) begin
                st <= DELAY;
                rc <= '0;
              end else if (rc == RP_LAST) begin
                press <= 1'b1;
                rc <= '0;
              end else rc <= rc + RW'(1);
            default: rc <= '0;
          endcase
      end
  end
endmodule

// File: tb/tb_joystick_conditioner.sv
// tb_joystick_conditioner: directed self-checking bench for joystick_conditioner
module tb_joystick_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] i_btn = '1;
  logic [4:0] i_repeat_en = '0;
  logic [4:0] o_level, o_press, o_release;
  logic o_any;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  joystick_conditioner #(
    .N_CH(5), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .i_repeat_en(i_repeat_en),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_any(o_any)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string tag, input logic [4:0] l, input logic [4:0] p, input logic [4:0] r);
    check({tag, ".level"}, 32'(o_level), 32'(l));
    check({tag, ".press"}, 32'(o_press), 32'(p));
    check({tag, ".release"}, 32'(o_release), 32'(r));
    check({tag, ".any"}, 32'(o_any), 32'(|l));
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int c = 0; c < 10; c++) begin
      i_btn = 5'($urandom);
      tick();
      check_all("in_reset", 5'd0, 5'd0, 5'd0);
    end
    i_btn = '1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_all("post_reset", 5'd0, 5'd0, 5'd0);
    end
    i_btn[0] = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      check_all("press0", c >= 6 ? 5'd1 : 5'd0, c == 6 ? 5'd1 : 5'd0, 5'd0);
      tick();
    end
    i_btn[0] = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      check_all("release0", c < 6 ? 5'd1 : 5'd0, 5'd0, c == 6 ? 5'd1 : 5'd0);
      tick();
    end
    for (int c = 0; c <= 29; c++) begin
      if (c % 2 == 0 && c <= 20) i_btn[2] = ((c / 2) % 2) == 1;
      check_all("bounce_press2", c >= 26 ? 5'b00100 : 5'd0, c == 26 ? 5'b00100 : 5'd0, 5'd0);
      tick();
    end
    for (int c = 0; c <= 29; c++) begin
      if (c % 2 == 0 && c <= 20) i_btn[2] = ((c / 2) % 2) == 0;
      check_all("bounce_release2", c < 26 ? 5'b00100 : 5'd0, 5'd0, c == 26 ? 5'b00100 : 5'd0);
      tick();
    end
    i_repeat_en[1] = 1'b1;
    i_btn[1] = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 22) i_btn[1] = 1'b1;
      check_all("repeat1", (c >= 6 && c < 28) ? 5'b00010 : 5'd0,
                (c == 6 || c == 16 || c == 19 || c == 22 || c == 25) ? 5'b00010 : 5'd0,
                c == 28 ? 5'b00010 : 5'd0);
      tick();
    end
    i_repeat_en[3] = 1'b1;
    i_btn[4:3] = 2'b00;
    for (int c = 0; c <= 50; c++) begin
      if (c == 11) i_repeat_en[3] = 1'b0;
      if (c == 26) i_repeat_en[3] = 1'b1;
      if (c == 41) i_btn[4:3] = 2'b11;
      check_all("multi34", (c >= 6 && c < 47) ? 5'b11000 : 5'd0,
                {c == 6, c == 6 || c == 36 || c == 39 || c == 42 || c == 45, 3'b000},
                c == 47 ? 5'b11000 : 5'd0);
      tick();
    end
    i_btn[1] = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      check_all("hold1", c >= 6 ? 5'b00010 : 5'd0, (c == 6 || c == 16) ? 5'b00010 : 5'd0, 5'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    check_all("rst_async", 5'd0, 5'd0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all("rst_hold", 5'd0, 5'd0, 5'd0);
    end
    rst = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      check_all("fresh1", c >= 6 ? 5'b00010 : 5'd0, c == 6 ? 5'b00010 : 5'd0, 5'd0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
